// File: rtl/lsu_arbiter.sv
// Arbitrates the shared 16-bit LSU between fetch and data ports, tracks the owner of the
// in-flight transaction and routes done pulses back. Define LSU_ARB_RR_EN for round-robin.
module lsu_arbiter (
  input  logic        clk,
  input  logic        a_rst,
  input  logic        f_req,
  input  logic [15:0] f_addr,
  output logic        f_ack,
  output logic        f_done,
  input  logic        d_req,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_data,
  input  logic        d_width,
  input  logic        d_cmd,
  input  logic        d_lock,
  output logic        d_ack,
  output logic        d_done,
  output logic [15:0] lsu_rq_addr,
  output logic        lsu_rq_wr_addr,
  output logic [15:0] lsu_rq_data,
  output logic        lsu_rq_width,
  output logic        lsu_rq_cmd,
  output logic        lsu_rq_t_id,
  output logic        lsu_rq_start,
  input  logic        lsu_rq_ack,
  input  logic        mem_rdy,
  input  logic        mem_bus_assert,
  input  logic        lsu_t_id
);

  typedef enum logic [1:0] {IDLE, OWN_F, OWN_D, LOCK_D} state_t;

  state_t state_q, state_d;
  logic   last_grant_q, last_grant_d;  // 1 = data port granted last
  logic   f_elig, d_elig;
  logic   sel_fetch, sel_data;
  logic   complete;

  always_comb begin
    f_elig = f_req & (state_q != LOCK_D) & ~a_rst;
    d_elig = d_req & ~a_rst;
`ifdef LSU_ARB_RR_EN
    if (f_elig & d_elig) sel_fetch = last_grant_q;
    else                 sel_fetch = f_elig;
`else
    sel_fetch = f_elig & ~d_elig;
`endif
    sel_data = d_elig & ~sel_fetch;
  end

`ifndef LSU_ARB_RR_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant_q;
`endif

  // With no data selection the mux rests on the fetch port, including during reset.
  assign lsu_rq_start   = f_elig | d_elig;
  assign lsu_rq_addr    = sel_data ? d_addr : f_addr;
  assign lsu_rq_data    = sel_data ? d_data : 16'h0000;
  assign lsu_rq_width   = sel_data ? d_width : 1'b1;
  assign lsu_rq_cmd     = sel_data & d_cmd;
  assign lsu_rq_t_id    = sel_data;
  assign lsu_rq_wr_addr = 1'b1;

  assign f_ack = lsu_rq_ack & sel_fetch;
  assign d_ack = lsu_rq_ack & sel_data;

  // A transaction still on the bus after reset belongs to nobody: IDLE suppresses its done.
  assign complete = mem_rdy & mem_bus_assert & (state_q != IDLE) & ~a_rst;
  assign f_done   = complete & ~lsu_t_id;
  assign d_done   = complete & lsu_t_id;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    if (f_ack) begin
      state_d      = OWN_F;
      last_grant_d = 1'b0;
    end else if (d_ack) begin
      state_d      = d_lock ? LOCK_D : OWN_D;
      last_grant_d = 1'b1;
    end else if (complete && (state_q != LOCK_D)) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: tb/tb_lsu_arbiter.sv
// Randomised scoreboard bench for lsu_arbiter: a behavioural ownership model plus a simple
// LSU/memory environment predict every ack and done; a separate monitor compares them.
module tb_lsu_arbiter;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst;
  logic        f_req, f_ack, f_done;
  logic [15:0] f_addr;
  logic        d_req, d_width, d_cmd, d_lock, d_ack, d_done;
  logic [15:0] d_addr, d_data;
  logic [15:0] lsu_rq_addr, lsu_rq_data;
  logic        lsu_rq_wr_addr, lsu_rq_width, lsu_rq_cmd, lsu_rq_t_id, lsu_rq_start;
  logic        lsu_rq_ack, mem_rdy, mem_bus_assert, lsu_t_id;
  logic        lsu_can_acc;

  assign lsu_rq_ack = lsu_rq_start & lsu_can_acc;

  lsu_arbiter dut (
    .clk(clk), .a_rst(a_rst),
    .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_done(f_done),
    .d_req(d_req), .d_addr(d_addr), .d_data(d_data), .d_width(d_width),
    .d_cmd(d_cmd), .d_lock(d_lock), .d_ack(d_ack), .d_done(d_done),
    .lsu_rq_addr(lsu_rq_addr), .lsu_rq_wr_addr(lsu_rq_wr_addr), .lsu_rq_data(lsu_rq_data),
    .lsu_rq_width(lsu_rq_width), .lsu_rq_cmd(lsu_rq_cmd), .lsu_rq_t_id(lsu_rq_t_id),
    .lsu_rq_start(lsu_rq_start), .lsu_rq_ack(lsu_rq_ack),
    .mem_rdy(mem_rdy), .mem_bus_assert(mem_bus_assert), .lsu_t_id(lsu_t_id)
  );

  typedef struct {
    int          cyc;
    bit          port;   // 0 = fetch, 1 = data
    logic [15:0] addr;
    logic [15:0] data;
    logic        width;
    logic        cmd;
  } ack_t;

  typedef struct {
    int cyc;
    bit id;
  } done_t;

  typedef enum int {M_IDLE, M_F, M_D, M_LOCK} own_t;

  ack_t  ack_q[$];
  done_t done_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  bit    active = 1'b0;
  bit    exp_start, exp_rst;
  logic [15:0] exp_rst_addr;

  // Reference model: who owns the LSU, who was granted last, outstanding ownership.
  own_t own = M_IDLE;
  bit   last_d = 1'b1;
  bit   owned = 1'b0;
  // Environment: the LSU/memory transaction currently on the bus.
  bit   env_busy = 1'b0;
  bit   env_id = 1'b0;
  int   env_rem = 0;
  // Requesters: pending request contents, held until acknowledged.
  bit          fp = 1'b0, dp = 1'b0;
  logic [15:0] fa = 16'h0, da = 16'h0, dd = 16'h0;
  logic        dw = 1'b0, dc = 1'b0, dl = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input int pf, input int pd, input int plk, input int lat, input int prst);
    bit r, ef, ed, gf, gd, acc, rdy, dn, busy_old;
    @(negedge clk);
    cyc++;
    r = (int'($urandom_range(99)) < prst);
    if (!fp && int'($urandom_range(99)) < pf) begin
      fp = 1'b1;
      fa = 16'($urandom);
    end
    if (!dp && int'($urandom_range(99)) < pd) begin
      dp = 1'b1;
      da = 16'($urandom);
      dd = 16'($urandom);
      dw = 1'($urandom);
      dc = 1'($urandom);
      dl = (int'($urandom_range(99)) < plk);
    end
    rdy = env_busy ? (env_rem == 0) : ($urandom_range(3) == 0);

    a_rst = r;
    f_req = fp; f_addr = fa;
    d_req = dp; d_addr = da; d_data = dd; d_width = dw; d_cmd = dc; d_lock = dl;
    mem_rdy = rdy; mem_bus_assert = env_busy; lsu_t_id = env_id;

    ef = fp && (own != M_LOCK) && !r;
    ed = dp && !r;
    if (ef && ed) begin
`ifdef LSU_ARB_RR_EN
      gf = last_d;
`else
      gf = 1'b0;
`endif
    end else begin
      gf = ef;
    end
    gd = ed && !gf;
    lsu_can_acc = !env_busy || rdy;
    acc = (gf || gd) && lsu_can_acc;
    dn = !r && rdy && env_busy && owned;

    exp_start = ef || ed;
    exp_rst = r;
    exp_rst_addr = fa;
    if (acc) ack_q.push_back('{cyc, gd, gd ? da : fa, gd ? dd : 16'h0000,
                               gd ? dw : 1'b1, gd ? dc : 1'b0});
    if (dn) done_q.push_back('{cyc, env_id});

    @(posedge clk);
    busy_old = env_busy;
    if (r) begin
      own = M_IDLE; last_d = 1'b1; owned = 1'b0;
    end else if (acc) begin
      own = gf ? M_F : (dl ? M_LOCK : M_D);
      last_d = gd;
      owned = 1'b1;
      if (gf) fp = 1'b0;
      else    dp = 1'b0;
    end else if (rdy && busy_old) begin
      owned = 1'b0;
      if (own != M_LOCK) own = M_IDLE;
    end

    if (acc) begin
      env_busy = 1'b1; env_id = gd; env_rem = int'($urandom_range(lat));
    end else if (env_busy) begin
      if (rdy) env_busy = 1'b0;
      else     env_rem--;
    end
  endtask

  // Monitor: checks the request strobe every cycle, and pops expected acks/dones when shown.
  initial begin
    ack_t  ea;
    done_t ed;
    forever begin
      @(negedge clk);
      #2;
      if (!active) continue;
      chk("lsu_rq_start", {31'b0, lsu_rq_start}, {31'b0, exp_start});
      if (exp_rst) begin
        chk("rst_strobes", {28'b0, f_ack, d_ack, f_done, d_done}, 32'h0);
        chk("rst_mux_addr", {16'b0, lsu_rq_addr}, {16'b0, exp_rst_addr});
        chk("rst_mux_ctl", {13'b0, lsu_rq_data, lsu_rq_width, lsu_rq_cmd, lsu_rq_t_id},
            {13'b0, 16'h0000, 1'b1, 1'b0, 1'b0});
      end
      while (ack_q.size() > 0 && ack_q[0].cyc < cyc) begin
        ea = ack_q.pop_front();
        chk("missing_ack", 32'h0, ea.cyc);
      end
      while (done_q.size() > 0 && done_q[0].cyc < cyc) begin
        ed = done_q.pop_front();
        chk("missing_done", 32'h0, ed.cyc);
      end
      if (f_ack && d_ack) chk("dual_ack", 32'h3, 32'h1);
      if (f_ack || d_ack) begin
        if (ack_q.size() == 0 || ack_q[0].cyc != cyc) begin
          chk("unexpected_ack", {30'b0, f_ack, d_ack}, 32'h0);
        end else begin
          ea = ack_q.pop_front();
          chk("ack_port", {31'b0, d_ack}, {31'b0, ea.port});
          chk("rq_addr", {16'b0, lsu_rq_addr}, {16'b0, ea.addr});
          chk("rq_data", {16'b0, lsu_rq_data}, {16'b0, ea.data});
          chk("rq_width_cmd", {30'b0, lsu_rq_width, lsu_rq_cmd}, {30'b0, ea.width, ea.cmd});
          chk("rq_tid_wraddr", {30'b0, lsu_rq_t_id, lsu_rq_wr_addr}, {30'b0, ea.port, 1'b1});
        end
      end
      if (f_done && d_done) chk("dual_done", 32'h3, 32'h1);
      if (f_done || d_done) begin
        if (done_q.size() == 0 || done_q[0].cyc != cyc) begin
          chk("unexpected_done", {30'b0, f_done, d_done}, 32'h0);
        end else begin
          ed = done_q.pop_front();
          chk("done_id", {31'b0, d_done}, {31'b0, ed.id});
        end
      end
    end
  end

  initial begin
    a_rst = 1'b1;
    f_req = 1'b0; f_addr = 16'h0;
    d_req = 1'b0; d_addr = 16'h0; d_data = 16'h0; d_width = 1'b0; d_cmd = 1'b0; d_lock = 1'b0;
    mem_rdy = 1'b0; mem_bus_assert = 1'b0; lsu_t_id = 1'b0; lsu_can_acc = 1'b0;
    active = 1'b1;
    for (int i = 0; i < 2; i++)    step(0, 0, 0, 0, 100);
    // Both ports requesting every cycle, single-cycle memory: alternation or data priority.
    for (int i = 0; i < 40; i++)   step(100, 100, 0, 0, 0);
    // Locked read-modify-write traffic against a persistent fetch requester.
    for (int i = 0; i < 300; i++)  step(100, 40, 50, 2, 0);
    // General mix with occasional asynchronous resets landing mid-transaction.
    for (int i = 0; i < 3000; i++) step(50, 50, 20, 3, 3);
    for (int i = 0; i < 1000; i++) step(30, 30, 10, 4, 1);
    active = 1'b0;
    chk("leftover_acks", ack_q.size(), 32'h0);
    chk("leftover_dones", done_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
